// File: rtl/bitpack_fetch_if.sv
// AXI4 read-address and read-data channels between the BitPack fetch
// front end (master) and the DDR interconnect (slave).
interface bitpack_fetch_if;
  logic        AXI_ARID;
  logic [31:0] AXI_ARADDR;
  logic [7:0]  AXI_ARLEN;
  logic [2:0]  AXI_ARSIZE;
  logic [1:0]  AXI_ARBURST;
  logic [3:0]  AXI_ARCACHE;
  logic [2:0]  AXI_ARPROT;
  logic        AXI_ARVALID;
  logic        AXI_ARREADY;
  logic        AXI_RID;
  logic [31:0] AXI_RDATA;
  logic [1:0]  AXI_RRESP;
  logic        AXI_RLAST;
  logic        AXI_RVALID;
  logic        AXI_RREADY;

  modport master (
    output AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST,
           AXI_ARCACHE, AXI_ARPROT, AXI_ARVALID, AXI_RREADY,
    input  AXI_ARREADY, AXI_RID, AXI_RDATA, AXI_RRESP, AXI_RLAST, AXI_RVALID
  );

  modport slave (
    input  AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST,
           AXI_ARCACHE, AXI_ARPROT, AXI_ARVALID, AXI_RREADY,
    output AXI_ARREADY, AXI_RID, AXI_RDATA, AXI_RRESP, AXI_RLAST, AXI_RVALID
  );
endinterface

// File: rtl/bitpack_fetch.sv
// BitPack fetch front end: splits a word-count request into 4 KB-safe AXI
// INCR bursts, issues one at a time only when the local FIFO can absorb the
// whole burst, and streams the buffered words out on a valid/ready port.
module bitpack_fetch #(
  parameter int BURST_LEN = 16,
  parameter int FIFO_AW   = 5
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic [31:0]           src_addr,
  input  logic [31:0]           word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  bitpack_fetch_if.master       axi,
  output logic [31:0]           m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {IDLE, CHECK, ADDR, DATA, DRAIN} state_t;

  state_t state, state_next;

  logic [31:0] addr;
  logic [31:0] rem;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [8:0]  burst_beats;
  logic        zero_job;
  logic        done_q;
  logic        error_q;

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   fifo_count;

  logic        start_ok;
  logic        ar_fire;
  logic        push;
  logic        pop;
  logic        last_beat;
  logic        drain_empty;
  logic        room;
  logic [31:0] page_words;
  logic [31:0] len;
  logic [31:0] free_words;
  logic        unused_rid;

  assign start_ok    = (state == IDLE) && start;
  assign ar_fire     = (state == ADDR) && axi.AXI_ARREADY;
  assign push        = (state == DATA) && axi.AXI_RVALID;
  assign last_beat   = push && axi.AXI_RLAST;
  assign pop         = m_valid && m_ready;
  // In DRAIN nothing is pushed, so the FIFO is empty after this edge when
  // it is already empty or its final word is being popped now.
  assign drain_empty = (fifo_count == '0) ||
                       ((fifo_count == (FIFO_AW+1)'(1)) && pop);
  assign unused_rid  = axi.AXI_RID;

  // Burst length: remaining words, capped by BURST_LEN and by the words left in the current 4 KB page
  always_comb begin
    page_words = 32'd1024 - {22'd0, addr[11:2]};
    len        = rem;
    if (len > 32'(BURST_LEN)) len = 32'(BURST_LEN);
    if (len > page_words)     len = page_words;
    free_words = 32'(DEPTH) - 32'(fifo_count);
    room       = free_words >= len;
  end

  // FSM state register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (word_count == 32'd0) ? DRAIN : CHECK;
      CHECK:   if (room) state_next = ADDR;
      ADDR:    if (axi.AXI_ARREADY) state_next = DATA;
      DATA:    if (last_beat) state_next = (rem != 32'd0) ? CHECK : DRAIN;
      DRAIN:   if (drain_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Job bookkeeping: address/remaining count, burst registers, done pulse and sticky error
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      addr        <= '0;
      rem         <= '0;
      ar_addr     <= '0;
      ar_len      <= '0;
      burst_beats <= '0;
      zero_job    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= (state == DRAIN) && drain_empty;
      if (start_ok) begin
        addr     <= {src_addr[31:2], 2'b00};
        rem      <= word_count;
        error_q  <= 1'b0;
        zero_job <= (word_count == 32'd0);
      end
      if ((state == CHECK) && room) begin
        ar_addr     <= addr;
        ar_len      <= 8'(len - 32'd1);
        burst_beats <= 9'(len);
      end
      if (ar_fire) begin
        addr <= addr + {21'd0, burst_beats, 2'b00};
        rem  <= rem - {23'd0, burst_beats};
      end
      if (push && (axi.AXI_RRESP != 2'b00)) error_q <= 1'b1;
    end
  end

  // FIFO storage, kept free of reset so it maps onto RAM
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= axi.AXI_RDATA;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign m_valid = (fifo_count != '0);
  assign m_data  = mem[rd_ptr];

  assign busy  = (state != IDLE) && !zero_job;
  assign done  = done_q;
  assign error = error_q;

  assign axi.AXI_ARID    = 1'b0;
  assign axi.AXI_ARADDR  = ar_addr;
  assign axi.AXI_ARLEN   = ar_len;
  assign axi.AXI_ARSIZE  = 3'b010;
  assign axi.AXI_ARBURST = 2'b01;
  assign axi.AXI_ARCACHE = 4'b0011;
  assign axi.AXI_ARPROT  = 3'b000;
  assign axi.AXI_ARVALID = (state == ADDR);
  assign axi.AXI_RREADY  = (state == DATA);

endmodule

// File: tb/tb_bitpack_fetch.sv
// Directed bench for bitpack_fetch: a zero-latency AXI slave whose memory
// word at byte address A holds A>>2, plus monitors on AR, the stream and
// the status outputs.
module tb_bitpack_fetch;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] word_count = '0;
  logic        busy, done, error;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;

  int assert_count = 0;
  int fail_count = 0;

  bitpack_fetch_if axi();

  bitpack_fetch #(.BURST_LEN(16), .FIFO_AW(5)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .src_addr(src_addr),
    .word_count(word_count), .busy(busy), .done(done), .error(error),
    .axi(axi), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 ACLK = ~ACLK;

  // Slave model: accepts one AR, then returns one beat per cycle
  logic        slv_active;
  logic [31:0] slv_addr;
  logic [8:0]  slv_left;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      slv_active <= 1'b0;
      slv_addr   <= '0;
      slv_left   <= '0;
    end else if (axi.AXI_ARVALID && axi.AXI_ARREADY) begin
      slv_active <= 1'b1;
      slv_addr   <= axi.AXI_ARADDR;
      slv_left   <= {1'b0, axi.AXI_ARLEN} + 9'd1;
    end else if (slv_active && axi.AXI_RREADY) begin
      slv_addr <= slv_addr + 32'd4;
      slv_left <= slv_left - 9'd1;
      if (slv_left == 9'd1) slv_active <= 1'b0;
    end
  end

  assign axi.AXI_ARREADY = !slv_active;
  assign axi.AXI_RVALID  = slv_active;
  assign axi.AXI_RDATA   = slv_addr >> 2;
  assign axi.AXI_RLAST   = (slv_left == 9'd1);
  assign axi.AXI_RRESP   = (slv_active && slv_addr == err_addr) ? 2'b10 : 2'b00;
  assign axi.AXI_RID     = 1'b0;

  // Monitors
  logic [31:0] rx_q[$];
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  int done_count, busy_cycles, arvalid_cycles;

  always @(posedge ACLK) begin
    if (ARESETN) begin
      if (m_valid && m_ready) rx_q.push_back(m_data);
      if (axi.AXI_ARVALID && axi.AXI_ARREADY) begin
        ar_addr_q.push_back(axi.AXI_ARADDR);
        ar_len_q.push_back(axi.AXI_ARLEN);
      end
      if (done) done_count++;
      if (busy) busy_cycles++;
      if (axi.AXI_ARVALID) arvalid_cycles++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMonitors();
    rx_q.delete();
    ar_addr_q.delete();
    ar_len_q.delete();
    done_count = 0;
    busy_cycles = 0;
    arvalid_cycles = 0;
  endtask

  // Pulses start for one cycle; returns at the negedge after the accepting edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] n);
    @(negedge ACLK);
    src_addr = a;
    word_count = n;
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  // lat counts cycles from the start pulse; one was already spent in applyStimulus
  task automatic waitDone(input string tag, input int budget, output int lat);
    bit seen = 0;
    lat = 1;
    if (done) seen = 1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge ACLK);
      lat++;
      if (done) seen = 1;
    end
    if (!seen) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic checkStream(input string tag, input int n, input logic [31:0] first);
    int errs = 0;
    checkOutput({tag, "_word_count"}, 32'(rx_q.size()), 32'(n));
    foreach (rx_q[i]) if (rx_q[i] !== first + 32'(i)) errs++;
    checkOutput({tag, "_word_order_errors"}, 32'(errs), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_arvalid"}, 32'(axi.AXI_ARVALID), 32'd0);
    checkOutput({tag, "_rready"},  32'(axi.AXI_RREADY),  32'd0);
    checkOutput({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, "_busy"},    32'(busy),    32'd0);
    checkOutput({tag, "_done"},    32'(done),    32'd0);
    checkOutput({tag, "_error"},   32'(error),   32'd0);
    checkOutput({tag, "_araddr"},  axi.AXI_ARADDR, 32'd0);
    checkOutput({tag, "_arlen"},   32'(axi.AXI_ARLEN), 32'd0);
  endtask

  initial begin
    int lat;
    int bad;
    bit hit;

    clearMonitors();
    repeat (3) @(negedge ACLK);
    checkResetValues("reset");
    ARESETN = 1'b1;
    checkOutput("arsize", 32'(axi.AXI_ARSIZE), 32'd2);
    checkOutput("arburst", 32'(axi.AXI_ARBURST), 32'd1);
    checkOutput("arcache", 32'(axi.AXI_ARCACHE), 32'd3);

    // 1024 words from 0x1000, stream always ready
    $display("[TB] long aligned transfer");
    m_ready = 1'b1;
    clearMonitors();
    applyStimulus(32'h1000, 32'h400);
    checkOutput("long_busy_after_start", 32'(busy), 32'd1);
    checkOutput("long_arvalid_in_check", 32'(axi.AXI_ARVALID), 32'd0);
    @(negedge ACLK);
    checkOutput("long_arvalid_first", 32'(axi.AXI_ARVALID), 32'd1);
    checkOutput("long_araddr_first", axi.AXI_ARADDR, 32'h1000);
    waitDone("long", 5000, lat);
    checkOutput("long_busy_with_done", 32'(busy), 32'd0);
    @(negedge ACLK);
    checkOutput("long_bursts", 32'(ar_addr_q.size()), 32'd64);
    bad = 0;
    foreach (ar_addr_q[i])
      if (ar_addr_q[i] !== 32'h1000 + 32'(i) * 32'h40 || ar_len_q[i] !== 8'd15) bad++;
    checkOutput("long_burst_errors", 32'(bad), 32'd0);
    checkStream("long", 1024, 32'h400);
    checkOutput("long_done_pulses", 32'(done_count), 32'd1);
    checkOutput("long_error", 32'(error), 32'd0);

    // 4 KB boundary split
    $display("[TB] page-crossing transfer");
    clearMonitors();
    applyStimulus(32'h0FF8, 32'd10);
    waitDone("page", 500, lat);
    @(negedge ACLK);
    checkOutput("page_bursts", 32'(ar_addr_q.size()), 32'd2);
    if (ar_addr_q.size() == 2) begin
      checkOutput("page_araddr0", ar_addr_q[0], 32'h0FF8);
      checkOutput("page_arlen0", 32'(ar_len_q[0]), 32'd1);
      checkOutput("page_araddr1", ar_addr_q[1], 32'h1000);
      checkOutput("page_arlen1", 32'(ar_len_q[1]), 32'd7);
    end
    checkStream("page", 10, 32'h3FE);

    // Back-pressure: FIFO fills, fetching pauses, then resumes
    $display("[TB] back-pressure transfer");
    m_ready = 1'b0;
    clearMonitors();
    applyStimulus(32'h2000, 32'd100);
    repeat (100) @(negedge ACLK);
    checkOutput("bp_words_while_stalled", 32'(rx_q.size()), 32'd0);
    checkOutput("bp_bursts_while_stalled", 32'(ar_addr_q.size()), 32'd2);
    checkOutput("bp_arvalid_while_full", 32'(axi.AXI_ARVALID), 32'd0);
    checkOutput("bp_m_valid_while_full", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    waitDone("bp", 1000, lat);
    @(negedge ACLK);
    checkOutput("bp_bursts", 32'(ar_addr_q.size()), 32'd7);
    checkStream("bp", 100, 32'h800);
    checkOutput("bp_done_pulses", 32'(done_count), 32'd1);

    // Zero-length job
    $display("[TB] zero-length job");
    clearMonitors();
    applyStimulus(32'h100, 32'd0);
    waitDone("zero", 20, lat);
    checkOutput("zero_done_latency", 32'(lat), 32'd2);
    @(negedge ACLK);
    checkOutput("zero_busy_cycles", 32'(busy_cycles), 32'd0);
    checkOutput("zero_arvalid_cycles", 32'(arvalid_cycles), 32'd0);
    checkOutput("zero_done_pulses", 32'(done_count), 32'd1);

    // Error response on beat 5 of 20
    $display("[TB] error response");
    clearMonitors();
    err_addr = 32'h3000 + 32'd16;
    applyStimulus(32'h3000, 32'd20);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (axi.AXI_RVALID && axi.AXI_RRESP != 2'b00) hit = 1;
      else @(negedge ACLK);
    end
    checkOutput("err_beat_seen", 32'(hit), 32'd1);
    checkOutput("err_before_beat", 32'(error), 32'd0);
    @(negedge ACLK);
    checkOutput("err_after_beat", 32'(error), 32'd1);
    waitDone("err", 500, lat);
    @(negedge ACLK);
    checkOutput("err_sticky_after_done", 32'(error), 32'd1);
    checkStream("err", 20, 32'hC00);
    err_addr = 32'hFFFF_FFFF;
    applyStimulus(32'h3000, 32'd4);
    checkOutput("err_cleared_by_start", 32'(error), 32'd0);
    waitDone("err_clear", 200, lat);
    @(negedge ACLK);

    // Reset during the data phase of the second burst
    $display("[TB] mid-transfer reset");
    clearMonitors();
    applyStimulus(32'h4000, 32'd64);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (ar_addr_q.size() == 2 && axi.AXI_RREADY) hit = 1;
      else @(negedge ACLK);
    end
    checkOutput("rst_reached_burst2", 32'(hit), 32'd1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    checkResetValues("midrst");
    ARESETN = 1'b1;
    clearMonitors();
    applyStimulus(32'h5000, 32'd20);
    waitDone("rst_fresh", 500, lat);
    @(negedge ACLK);
    checkStream("rst_fresh", 20, 32'h1400);
    checkOutput("rst_fresh_done_pulses", 32'(done_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
